// File: rtl/ex_checker.sv
// rtl/ex_checker.sv - in-order execute-result checker against a FIFO of expected entries
module ex_checker #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exp_valid,
  input  logic [4:0]  exp_rd,
  input  logic [63:0] exp_data,
  output logic        exp_ready,
  input  logic        res_valid,
  input  logic [4:0]  res_rd,
  input  logic [63:0] res_data,
  input  logic        stall,
  input  logic        clear,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic [1:0]  state,
  output logic        error,
  output logic [4:0]  first_fail_rd,
  output logic [63:0] first_fail_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [15:0]   pass_cnt_q, pass_cnt_d;
  logic [15:0]   fail_cnt_q, fail_cnt_d;
  logic          error_q, error_d;
  logic [4:0]    ff_rd_q, ff_rd_d;
  logic [63:0]   ff_data_q, ff_data_d;
  logic [68:0]   mem_q [DEPTH];

  logic          empty, full, push, retire, is_match, fail_now, timeout_hit;
  logic [4:0]    head_rd;
  logic [63:0]   head_data;

  // Extra pointer bit tells full from empty when the indices coincide
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign exp_ready = !full && (state_q != ST_FAIL);
  assign {head_rd, head_data} = mem_q[rd_ptr_q[AW-1:0]];

  assign state           = state_q;
  assign pass_cnt        = pass_cnt_q;
  assign fail_cnt        = fail_cnt_q;
  assign error           = error_q;
  assign first_fail_rd   = ff_rd_q;
  assign first_fail_data = ff_data_q;

  // Next-state: FIFO pointers, timeout, compare outcome, counters and FSM
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    to_cnt_d   = to_cnt_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ff_rd_d    = ff_rd_q;
    ff_data_d  = ff_data_q;

    // clear wins over both push and retire in the same cycle
    push     = exp_valid && exp_ready && !clear;
    retire   = res_valid && !stall && (state_q != ST_FAIL) && !clear;
    // x0 writes are architecturally discarded, so only the register index matters
    is_match = (res_rd == head_rd) && ((head_rd == 5'd0) || (res_data == head_data));
    fail_now = retire && (empty || !is_match);

    if (clear) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push)            wr_ptr_d = wr_ptr_q + 1'b1;
      if (retire && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (retire || clear || empty || (state_q != ST_RUN)) to_cnt_d = '0;
    else                                                 to_cnt_d = to_cnt_q + TW'(1);
    timeout_hit = (state_q == ST_RUN) && (to_cnt_d == TW'(TIMEOUT));

    if (retire) begin
      if (fail_now) begin
        if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
      end else begin
        if (pass_cnt_q != 16'hFFFF) pass_cnt_d = pass_cnt_q + 16'd1;
      end
    end

    if (state_q != ST_FAIL) begin
      if (fail_now) begin
        state_d   = ST_FAIL;
        ff_rd_d   = res_rd;
        ff_data_d = res_data;
      end else if (timeout_hit) begin
        state_d = ST_FAIL;
      end else if (push) begin
        state_d = ST_RUN;
      end
    end

    error_d = (state_d == ST_FAIL);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      to_cnt_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      error_q    <= 1'b0;
      ff_rd_q    <= '0;
      ff_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      to_cnt_q   <= to_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      error_q    <= error_d;
      ff_rd_q    <= ff_rd_d;
      ff_data_q  <= ff_data_d;
    end
  end

  // Expected-entry storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {exp_rd, exp_data};
  end

endmodule

// File: tb/tb_ex_checker.sv
// tb/tb_ex_checker.sv - directed vector bench for ex_checker
module tb_ex_checker;

  logic        clk = 1'b0;
  logic        reset, exp_valid, res_valid, stall, clear;
  logic [4:0]  exp_rd, res_rd;
  logic [63:0] exp_data, res_data;
  logic        exp_ready, error;
  logic [15:0] pass_cnt, fail_cnt;
  logic [1:0]  state;
  logic [4:0]  first_fail_rd;
  logic [63:0] first_fail_data;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    bit          r, ev;
    logic [4:0]  erd;
    logic [63:0] ed;
    bit          rv;
    logic [4:0]  rrd;
    logic [63:0] rdat;
    bit          st, clr;
    bit          rdy;
    int          p, f, s;
    logic [4:0]  frd;
    logic [63:0] fd;
  } vec_t;

  vec_t vecs[$];

  ex_checker #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_rd(exp_rd), .exp_data(exp_data), .exp_ready(exp_ready),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
    .stall(stall), .clear(clear),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .state(state), .error(error),
    .first_fail_rd(first_fail_rd), .first_fail_data(first_fail_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input bit r, input bit ev, input logic [4:0] erd, input logic [63:0] ed,
                     input bit rv, input logic [4:0] rrd, input logic [63:0] rdat,
                     input bit st, input bit clr,
                     input bit rdy, input int p, input int f, input int s,
                     input logic [4:0] frd, input logic [63:0] fd);
    vec_t v;
    v.r = r; v.ev = ev; v.erd = erd; v.ed = ed; v.rv = rv; v.rrd = rrd; v.rdat = rdat;
    v.st = st; v.clr = clr; v.rdy = rdy; v.p = p; v.f = f; v.s = s; v.frd = frd; v.fd = fd;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit r, input bit ev, input logic [4:0] erd, input logic [63:0] ed,
                       input bit rv, input logic [4:0] rrd, input logic [63:0] rdat,
                       input bit st, input bit clr);
    reset = r; exp_valid = ev; exp_rd = erd; exp_data = ed;
    res_valid = rv; res_rd = rrd; res_data = rdat; stall = st; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input bit rdy, input int p, input int f, input int s,
                         input logic [4:0] frd, input logic [63:0] fd);
    chk({tag, ".exp_ready"}, 64'(exp_ready), 64'(rdy));
    chk({tag, ".pass_cnt"}, 64'(pass_cnt), 64'(p));
    chk({tag, ".fail_cnt"}, 64'(fail_cnt), 64'(f));
    chk({tag, ".state"}, 64'(state), 64'(s));
    chk({tag, ".error"}, 64'(error), 64'(s == 2));
    chk({tag, ".first_fail_rd"}, 64'(first_fail_rd), 64'(frd));
    chk({tag, ".first_fail_data"}, first_fail_data, fd);
  endtask

  initial begin
    //   r ev erd  ed        rv rrd rdat      st clr | rdy p f s frd fd
    add(1, 0, 0,  0,        0, 0,  0,        0, 0,   1, 0, 0, 0, 0,  0);
    add(0, 1, 5,  'h300,    0, 0,  0,        0, 0,   1, 0, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 5,  'h300,    0, 0,   1, 1, 0, 1, 0,  0);
    add(0, 1, 0,  'h1234,   0, 0,  0,        0, 0,   1, 1, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 0,  'hDEAD,   0, 0,   1, 2, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 5,  'h1,      1, 0,   1, 2, 0, 1, 0,  0);
    add(0, 1, 1,  'h11,     0, 0,  0,        0, 0,   1, 2, 0, 1, 0,  0);
    add(0, 1, 2,  'h22,     0, 0,  0,        0, 0,   1, 2, 0, 1, 0,  0);
    add(0, 1, 3,  'h33,     0, 0,  0,        0, 0,   1, 2, 0, 1, 0,  0);
    add(0, 1, 4,  'h44,     0, 0,  0,        0, 0,   0, 2, 0, 1, 0,  0);
    add(0, 1, 6,  'h66,     0, 0,  0,        0, 0,   0, 2, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 1,  'h11,     0, 0,   1, 3, 0, 1, 0,  0);
    add(0, 1, 7,  'h77,     1, 2,  'h22,     0, 0,   1, 4, 0, 1, 0,  0);
    add(0, 1, 8,  'h88,     0, 0,  0,        0, 0,   0, 4, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 3,  'h33,     0, 0,   1, 5, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 4,  'h44,     0, 0,   1, 6, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 7,  'h77,     0, 0,   1, 7, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 8,  'h88,     0, 0,   1, 8, 0, 1, 0,  0);
    add(0, 1, 9,  'h99,     1, 9,  'h99,     0, 0,   0, 8, 1, 2, 9,  'h99);
    add(1, 0, 0,  0,        0, 0,  0,        0, 0,   1, 0, 0, 0, 0,  0);
    add(0, 1, 5,  'h300,    0, 0,  0,        0, 0,   1, 0, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 5,  'h301,    0, 0,   0, 0, 1, 2, 5,  'h301);
    add(0, 1, 5,  'h300,    1, 5,  'h300,    0, 0,   0, 0, 1, 2, 5,  'h301);
    add(1, 0, 0,  0,        0, 0,  0,        0, 0,   1, 0, 0, 0, 0,  0);
    add(0, 0, 0,  0,        1, 12, 'hABC,    0, 0,   0, 0, 1, 2, 12, 'hABC);
    add(1, 1, 1,  'h1,      1, 3,  'h3,      0, 0,   1, 0, 0, 0, 0,  0);
    add(0, 1, 3,  'h5,      0, 0,  0,        0, 0,   1, 0, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 4,  'h5,      0, 0,   0, 0, 1, 2, 4,  'h5);
    add(1, 0, 0,  0,        0, 0,  0,        0, 0,   1, 0, 0, 0, 0,  0);
    add(0, 1, 1,  'h1,      0, 0,  0,        0, 0,   1, 0, 0, 1, 0,  0);
    add(0, 1, 2,  'h2,      0, 0,  0,        0, 0,   1, 0, 0, 1, 0,  0);
    add(0, 1, 3,  'h3,      1, 1,  'h1,      0, 1,   1, 0, 0, 1, 0,  0);
    add(0, 0, 0,  0,        1, 1,  'h1,      0, 0,   0, 0, 1, 2, 1,  'h1);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].ev, vecs[i].erd, vecs[i].ed, vecs[i].rv, vecs[i].rrd,
            vecs[i].rdat, vecs[i].st, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].p, vecs[i].f, vecs[i].s,
              vecs[i].frd, vecs[i].fd);
      @(negedge clk);
    end

    // Cleared FIFO with stalled results held for 20 cycles: no timeout, no retire
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 1, 'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 2, 'h20, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      drive(0, 0, 0, 0, 1, 1, 'h10, 1, 0);
      @(negedge clk);
    end
    chk_all("clear_stall", 1, 0, 0, 1, 0, 0);

    // One pending entry, stalled: still running after 15 cycles, FAIL on the 16th
    drive(0, 1, 6, 'h60, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int c = 0; c < 15; c++) begin
      drive(0, 0, 0, 0, 1, 6, 'h60, 1, 0);
      @(negedge clk);
    end
    chk("timeout_pre.state", 64'(state), 64'd1);
    drive(0, 0, 0, 0, 1, 6, 'h60, 1, 0);
    chk_all("timeout", 0, 0, 0, 2, 0, 0);
    @(negedge clk);

    // Reset out of FAIL
    drive(1, 1, 3, 'h3, 1, 3, 'h3, 0, 0);
    chk_all("reset_from_fail", 1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
